// File: rtl/spk_mem_pkg.sv
// Shared spike-memory types and helpers: FSM state encoding, field-index width calc,
// and generic sub-word field insert/extract used by several spike-memory blocks.
// Pure package; no latency or backpressure of its own.
package spk_mem_pkg;

    // Widest SRAM word any spike-memory block may use with the field helpers.
    localparam int MAX_DATA_W = 64;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_RMW_MERGE = 1'b1
    } state_t;

    // Field-index width; kept at least 1 so a single-field word still has a legal port.
    function automatic int calc_sel_w(input int data_w, input int field_w);
        int n_fields;
        n_fields = data_w / field_w;
        return (n_fields > 1) ? $clog2(n_fields) : 1;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] field_mask(input int sel, input int field_w);
        logic [MAX_DATA_W-1:0] m;
        m = (MAX_DATA_W'(1) << field_w) - MAX_DATA_W'(1);
        return m << (sel * field_w);
    endfunction

    function automatic logic [MAX_DATA_W-1:0] field_extract(
        input logic [MAX_DATA_W-1:0] word, input int sel, input int field_w);
        return (word >> (sel * field_w)) & field_mask(0, field_w);
    endfunction

    function automatic logic [MAX_DATA_W-1:0] field_insert(
        input logic [MAX_DATA_W-1:0] word, input int sel, input int field_w,
        input logic [MAX_DATA_W-1:0] fdata);
        return (word & ~field_mask(sel, field_w)) |
               ((fdata << (sel * field_w)) & field_mask(sel, field_w));
    endfunction

endpackage

// File: rtl/spk_mem_arbiter_if.sv
// Client + SRAM bus bundle for spk_mem_arbiter: per-client request/grant/read-return
// signals and the single-port SRAM command/return pins. No logic, no latency.
// slave = arbiter side, master = controller/SRAM side.
interface spk_mem_arbiter_if
    import spk_mem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 9,
    parameter int FIELD_W = 2,
    parameter int N_CH    = 4,
    parameter int SEL_W   = calc_sel_w(DATA_W, FIELD_W)
);
    logic [N_CH-1:0]        ch_req;
    logic [N_CH-1:0]        ch_we;
    logic [N_CH-1:0]        ch_part;
    logic [N_CH*ADDR_W-1:0] ch_addr;
    logic [N_CH*SEL_W-1:0]  ch_sel;
    logic [N_CH*DATA_W-1:0] ch_wdata;
    logic [N_CH-1:0]        ch_gnt;
    logic [N_CH-1:0]        rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic [FIELD_W-1:0]     rd_field;
    logic                   sram_en;
    logic                   sram_we;
    logic [ADDR_W-1:0]      sram_addr;
    logic [DATA_W-1:0]      sram_wdata;
    logic [DATA_W-1:0]      sram_rdata;

    modport slave (
        input  ch_req, ch_we, ch_part, ch_addr, ch_sel, ch_wdata, sram_rdata,
        output ch_gnt, rd_valid, rd_data, rd_field, sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output ch_req, ch_we, ch_part, ch_addr, ch_sel, ch_wdata, sram_rdata,
        input  ch_gnt, rd_valid, rd_data, rd_field, sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/spk_rr_arbiter.sv
// Round-robin pick: first requester at or after i_ptr, plus the pointer to use next.
// Latency 0 (purely combinational, stateless; the pointer register lives in the parent).
// No backpressure: losers simply see no grant and keep requesting.
// Ports: i_req (requests), i_ptr (priority start), o_gnt (one-hot), o_next_ptr (winner+1 mod N).
module spk_rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_CH-1:0]  o_gnt,
    output logic [PTR_W-1:0] o_next_ptr
);
    int   w_idx;
    logic w_found;

    always_comb begin
        o_gnt      = '0;
        o_next_ptr = i_ptr;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = (int'(i_ptr) + k) % N_CH;
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_next_ptr   = PTR_W'((w_idx + 1) % N_CH);
            end
        end
    end
endmodule

// File: rtl/spk_mem_arbiter.sv
// Shares one single-port sync SRAM among N_CH clients: round-robin grant, tagged reads, RMW field writes.
// Grant 0 cycles; read data 1 cycle after grant; field write occupies the SRAM for 2 cycles.
// Clients hold ch_req until granted; no grants are issued during the RMW merge cycle.
// Ports: clk, rst (async, active high) and bus (client requests/grants/read return + SRAM pins).
module spk_mem_arbiter
    import spk_mem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 9,
    parameter int FIELD_W = 2,
    parameter int N_CH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    spk_mem_arbiter_if.slave  bus
);
    // Field helpers work on MAX_DATA_W-wide words, so DATA_W must not exceed it.
    localparam int SEL_W = calc_sel_w(DATA_W, FIELD_W);
    localparam int PTR_W = $clog2(N_CH);

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [N_CH-1:0]    r_rd_vld;
    logic [SEL_W-1:0]   r_rd_sel;
    logic [ADDR_W-1:0]  r_rmw_addr;
    logic [SEL_W-1:0]   r_rmw_sel;
    logic [FIELD_W-1:0] r_rmw_fdat;

    state_t             w_state_nxt;
    logic [N_CH-1:0]    w_arb_req;
    logic [N_CH-1:0]    w_gnt;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [ADDR_W-1:0]  w_addr;
    logic [SEL_W-1:0]   w_sel;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_we;
    logic               w_part;
    logic               w_rd_issue;
    logic               w_rmw_start;
    logic               w_sram_en;
    logic               w_sram_we;
    logic [ADDR_W-1:0]  w_sram_addr;
    logic [DATA_W-1:0]  w_sram_wdata;
    logic [DATA_W-1:0]  w_merged;
    logic [DATA_W-1:0]  w_rd_data;

    // Arbitration only runs in IDLE and never while reset is held, so ch_gnt is 0 in both cases.
    assign w_arb_req = (r_state == ST_IDLE && !rst) ? bus.ch_req : '0;

    spk_rr_arbiter #(.N_CH(N_CH), .PTR_W(PTR_W)) u_rr (
        .i_req      (w_arb_req),
        .i_ptr      (r_ptr),
        .o_gnt      (w_gnt),
        .o_next_ptr (w_next_ptr)
    );

    // Winner's command fields, selected by the one-hot grant.
    always_comb begin
        w_addr  = '0;
        w_sel   = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        w_part  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt[i]) begin
                w_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
                w_sel   = bus.ch_sel[i*SEL_W +: SEL_W];
                w_wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
                w_we    = bus.ch_we[i];
                w_part  = bus.ch_part[i];
            end
        end
    end

    // Old word arrives on sram_rdata in the merge cycle; splice the latched field into it.
    assign w_merged = DATA_W'(field_insert(MAX_DATA_W'(bus.sram_rdata), int'(r_rmw_sel),
                                           FIELD_W, MAX_DATA_W'(r_rmw_fdat)));

    always_comb begin
        w_state_nxt  = r_state;
        w_sram_en    = 1'b0;
        w_sram_we    = 1'b0;
        w_sram_addr  = '0;
        w_sram_wdata = '0;
        w_rd_issue   = 1'b0;
        w_rmw_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_gnt) begin
                    w_sram_en   = 1'b1;
                    w_sram_addr = w_addr;
                    if (w_we && !w_part) begin
                        w_sram_we    = 1'b1;
                        w_sram_wdata = w_wdata;
                    end else if (w_we) begin
                        // Field write: read the old word now, write the merge next cycle.
                        w_rmw_start = 1'b1;
                        w_state_nxt = ST_RMW_MERGE;
                    end else begin
                        w_rd_issue = 1'b1;
                    end
                end
            end
            ST_RMW_MERGE: begin
                w_sram_en    = 1'b1;
                w_sram_we    = 1'b1;
                w_sram_addr  = r_rmw_addr;
                w_sram_wdata = w_merged;
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Reset forces the SRAM idle at once, which also aborts a merge in progress.
        if (rst) begin
            w_sram_en    = 1'b0;
            w_sram_we    = 1'b0;
            w_sram_addr  = '0;
            w_sram_wdata = '0;
            w_rd_issue   = 1'b0;
            w_rmw_start  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_rd_vld   <= '0;
            r_rd_sel   <= '0;
            r_rmw_addr <= '0;
            r_rmw_sel  <= '0;
            r_rmw_fdat <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_vld <= w_rd_issue ? w_gnt : '0;
            if (|w_gnt) begin
                r_ptr <= w_next_ptr;
            end
            if (w_rd_issue) begin
                r_rd_sel <= w_sel;
            end
            if (w_rmw_start) begin
                r_rmw_addr <= w_addr;
                r_rmw_sel  <= w_sel;
                r_rmw_fdat <= w_wdata[FIELD_W-1:0];
            end
        end
    end

    // r_rd_vld is cleared by reset, so the read return is 0 while rst is high.
    assign w_rd_data = (|r_rd_vld) ? bus.sram_rdata : '0;

    assign bus.ch_gnt     = w_gnt;
    assign bus.rd_valid   = r_rd_vld;
    assign bus.rd_data    = w_rd_data;
    assign bus.rd_field   = FIELD_W'(field_extract(MAX_DATA_W'(w_rd_data), int'(r_rd_sel), FIELD_W));
    assign bus.sram_en    = w_sram_en;
    assign bus.sram_we    = w_sram_we;
    assign bus.sram_addr  = w_sram_addr;
    assign bus.sram_wdata = w_sram_wdata;

endmodule

// File: tb/tb_spk_mem_arbiter.sv
// Directed bench for spk_mem_arbiter with a behavioural single-port sync SRAM model.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Every comparison is an immediate assertion; failures are counted and reported.
module tb_spk_mem_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [15:0] mem [0:511];

    spk_mem_arbiter_if #(.DATA_W(16), .ADDR_W(9), .FIELD_W(2), .N_CH(4)) bus ();

    spk_mem_arbiter #(.DATA_W(16), .ADDR_W(9), .FIELD_W(2), .N_CH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous SRAM: read data registered, one cycle after enable.
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
            else             bus.sram_rdata <= mem[bus.sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic req, input logic we, input logic part,
                          input logic [8:0] addr, input logic [2:0] sel, input logic [15:0] wd);
        bus.ch_req[i]             = req;
        bus.ch_we[i]              = we;
        bus.ch_part[i]            = part;
        bus.ch_addr[i*9 +: 9]     = addr;
        bus.ch_sel[i*3 +: 3]      = sel;
        bus.ch_wdata[i*16 +: 16]  = wd;
    endtask

    task automatic clr_all();
        for (int i = 0; i < 4; i++) set_ch(i, 1'b0, 1'b0, 1'b0, 9'd0, 3'd0, 16'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"},   32'(bus.ch_gnt), 32'h0);
        chk({tag, ".en"},    32'(bus.sram_en), 32'h0);
        chk({tag, ".we"},    32'(bus.sram_we), 32'h0);
        chk({tag, ".addr"},  32'(bus.sram_addr), 32'h0);
        chk({tag, ".wdata"}, 32'(bus.sram_wdata), 32'h0);
        chk({tag, ".rdv"},   32'(bus.rd_valid), 32'h0);
        chk({tag, ".rdd"},   32'(bus.rd_data), 32'h0);
        chk({tag, ".rdf"},   32'(bus.rd_field), 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 512; a++) mem[a] = 16'h0;
        bus.sram_rdata = 16'h0;
        rst = 1'b1;
        clr_all();

        // Reset: outputs zero even with every client requesting.
        #2;
        for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 1'b1, 1'b0, 9'(i + 1), 3'd1, 16'hFFFF);
        #1;
        chk_all_zero("reset");
        clr_all();
        nxt();
        nxt();
        rst = 1'b0;
        #1;
        chk("idle.en", 32'(bus.sram_en), 32'h0);

        // Single read: client 1, addr 5, sel 3.
        mem[5] = 16'hA5C3;
        nxt();
        set_ch(1, 1'b1, 1'b0, 1'b0, 9'd5, 3'd3, 16'h0);
        #1;
        chk("rd.gnt",  32'(bus.ch_gnt), 32'h2);
        chk("rd.en",   32'(bus.sram_en), 32'h1);
        chk("rd.we",   32'(bus.sram_we), 32'h0);
        chk("rd.addr", 32'(bus.sram_addr), 32'd5);
        chk("rd.rdv0", 32'(bus.rd_valid), 32'h0);
        nxt();
        clr_all();
        #1;
        chk("rd.rdv",  32'(bus.rd_valid), 32'h2);
        chk("rd.data", 32'(bus.rd_data), 32'hA5C3);
        chk("rd.fld",  32'(bus.rd_field), 32'h3);
        nxt();
        chk("rd.rdv_after", 32'(bus.rd_valid), 32'h0);

        // Contention from a fresh reset: all four read continuously -> 0,1,2,3,0,...
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 1'b0, 1'b0, 9'(40 + i), 3'd0, 16'h0);
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("cont.gnt%0d", k), 32'(bus.ch_gnt), 32'(1 << (k % 4)));
            chk($sformatf("cont.addr%0d", k), 32'(bus.sram_addr), 32'(40 + (k % 4)));
            if (k > 0) chk($sformatf("cont.rdv%0d", k), 32'(bus.rd_valid), 32'(1 << ((k - 1) % 4)));
            nxt();
        end
        clr_all();
        #1;
        chk("cont.rdv_last", 32'(bus.rd_valid), 32'h8);
        chk("cont.gnt_none", 32'(bus.ch_gnt), 32'h0);

        // Field write: client 2, addr 9, sel 7, field 2'b10 (upper wdata bits must be ignored).
        nxt();
        mem[9] = 16'h0000;
        set_ch(2, 1'b1, 1'b1, 1'b1, 9'd9, 3'd7, 16'hFFFE);
        #1;
        chk("fw.gnt",  32'(bus.ch_gnt), 32'h4);
        chk("fw.en",   32'(bus.sram_en), 32'h1);
        chk("fw.we0",  32'(bus.sram_we), 32'h0);
        chk("fw.addr", 32'(bus.sram_addr), 32'd9);
        nxt();
        clr_all();
        set_ch(0, 1'b1, 1'b0, 1'b0, 9'd1, 3'd0, 16'h0);
        #1;
        chk("fw.gnt1",  32'(bus.ch_gnt), 32'h0);
        chk("fw.we1",   32'(bus.sram_we), 32'h1);
        chk("fw.addr1", 32'(bus.sram_addr), 32'd9);
        chk("fw.wdata", 32'(bus.sram_wdata), 32'h8000);
        chk("fw.rdv",   32'(bus.rd_valid), 32'h0);
        nxt();
        // Client 0 was held off during the merge and is served now.
        chk("fw.mem",      32'(mem[9]), 32'h8000);
        chk("fw.pend_gnt", 32'(bus.ch_gnt), 32'h1);
        nxt();
        clr_all();
        set_ch(3, 1'b1, 1'b0, 1'b0, 9'd9, 3'd7, 16'h0);
        #1;
        chk("fw.rd_gnt", 32'(bus.ch_gnt), 32'h8);
        nxt();
        clr_all();
        #1;
        chk("fw.rd_rdv",  32'(bus.rd_valid), 32'h8);
        chk("fw.rd_data", 32'(bus.rd_data), 32'h8000);
        chk("fw.rd_fld",  32'(bus.rd_field), 32'h2);

        // Field write by client 1 then full write by client 3 to the same word.
        nxt();
        mem[20] = 16'h00FF;
        set_ch(1, 1'b1, 1'b1, 1'b1, 9'd20, 3'd0, 16'h0001);
        set_ch(3, 1'b1, 1'b1, 1'b0, 9'd20, 3'd0, 16'hBEEF);
        #1;
        chk("ff.gnt_g", 32'(bus.ch_gnt), 32'h2);
        nxt();
        set_ch(1, 1'b0, 1'b0, 1'b0, 9'd0, 3'd0, 16'h0);
        #1;
        chk("ff.gnt_g1",   32'(bus.ch_gnt), 32'h0);
        chk("ff.merge_wd", 32'(bus.sram_wdata), 32'h00FD);
        nxt();
        chk("ff.gnt_g2",  32'(bus.ch_gnt), 32'h8);
        chk("ff.we_g2",   32'(bus.sram_we), 32'h1);
        chk("ff.wd_g2",   32'(bus.sram_wdata), 32'hBEEF);
        nxt();
        clr_all();
        chk("ff.mem", 32'(mem[20]), 32'hBEEF);

        // Write then read of the same address on consecutive grants.
        set_ch(0, 1'b1, 1'b1, 1'b0, 9'd3, 3'd0, 16'h1234);
        #1;
        chk("wr.gnt", 32'(bus.ch_gnt), 32'h1);
        chk("wr.we",  32'(bus.sram_we), 32'h1);
        nxt();
        clr_all();
        set_ch(1, 1'b1, 1'b0, 1'b0, 9'd3, 3'd2, 16'h0);
        #1;
        chk("wr.rd_gnt", 32'(bus.ch_gnt), 32'h2);
        nxt();
        clr_all();
        #1;
        chk("wr.rdv",  32'(bus.rd_valid), 32'h2);
        chk("wr.rdd",  32'(bus.rd_data), 32'h1234);
        chk("wr.rdf",  32'(bus.rd_field), 32'h3);

        // Reset during the merge cycle aborts the write and clears the pointer.
        nxt();
        mem[30] = 16'h5555;
        set_ch(2, 1'b1, 1'b1, 1'b1, 9'd30, 3'd1, 16'h0003);
        #1;
        chk("rr.gnt", 32'(bus.ch_gnt), 32'h4);
        nxt();
        clr_all();
        rst = 1'b1;
        #1;
        chk_all_zero("rr.abort");
        nxt();
        chk("rr.mem", 32'(mem[30]), 32'h5555);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 1'b0, 1'b0, 9'(50 + i), 3'd0, 16'h0);
        #1;
        chk("rr.ptr0_gnt",  32'(bus.ch_gnt), 32'h1);
        chk("rr.ptr0_addr", 32'(bus.sram_addr), 32'd50);
        nxt();
        clr_all();

        // A read in flight when reset hits never returns.
        set_ch(3, 1'b1, 1'b0, 1'b0, 9'd5, 3'd0, 16'h0);
        #1;
        chk("fl.gnt", 32'(bus.ch_gnt), 32'h8);
        nxt();
        clr_all();
        rst = 1'b1;
        #1;
        chk("fl.rdv", 32'(bus.rd_valid), 32'h0);
        chk("fl.rdd", 32'(bus.rd_data), 32'h0);
        nxt();
        rst = 1'b0;
        nxt();
        chk("fl.rdv_post", 32'(bus.rd_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spk_mem_arbiter.md
# spk_mem_arbiter

Parametrised, sequential successor to the spike-memory wiring layer. It lets N_CH controller clients (spikability read/write, AC/input spike read, spike write) share one single-port synchronous SRAM bank. It provides round-robin arbitration, a one-cycle registered read path with sub-word field extraction, and read-modify-write for sub-word (field) writes, which the SRAM macro does not support natively. It sits between the layer controller and each SRAM macro; one instance per bank.

## Interface
- DATA_W, 16, SRAM word width
- ADDR_W, 9, SRAM address width
- FIELD_W, 2, sub-word field width; DATA_W % FIELD_W == 0
- N_CH, 4, number of clients (≥2)
- SEL_W (derived), clog2(DATA_W/FIELD_W), field index width

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ch_req  in  N_CH  per-client request, held until granted
- ch_we  in  N_CH  1 = write, 0 = read
- ch_part  in  N_CH  1 = field (sub-word) access; for writes, triggers RMW
- ch_addr  in  N_CH*ADDR_W  flattened addresses, client i at [i*ADDR_W +: ADDR_W]
- ch_sel  in  N_CH*SEL_W  flattened field index
- ch_wdata  in  N_CH*DATA_W  flattened write data; field writes use bits [FIELD_W-1:0]
- ch_gnt  out  N_CH  one-hot grant; request consumed in the cycle req && gnt
- rd_valid  out  N_CH  one-hot read-data-valid, tagged to the requesting client
- rd_data  out  DATA_W  full read word
- rd_field  out  FIELD_W  field rd_data[sel*FIELD_W +: FIELD_W] using the granted sel
- sram_en  out  1  SRAM enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after enabled read

## Operation
- States: IDLE, RMW_MERGE.
- IDLE: the round-robin arbiter picks the first requesting client at or after pointer `ptr`. ch_gnt is combinational in the same cycle (cycle G). The SRAM command is issued in cycle G.
  - Full write (we=1, part=0): sram_en=1, sram_we=1, sram_wdata = client wdata. Stay in IDLE.
  - Read (we=0): sram_en=1, sram_we=0. Latch client index and sel. Stay in IDLE.
  - Field write (we=1, part=1): sram_en=1, sram_we=0 (read old word). Latch index, addr, sel, and the field data. Go to RMW_MERGE.
- RMW_MERGE: sram_en=1, sram_we=1, sram_addr = latched addr. sram_wdata = sram_rdata with the latched field replaced. No grant. Return to IDLE.
- Pointer update: after granting client i, `ptr` ← (i+1) mod N_CH. Held when nothing is granted.
- When no request is pending: sram_en=0, sram_we=0. sram_addr and sram_wdata are don't-care; the implementation drives 0.
- Read response: in cycle G+1, rd_valid[i]=1, rd_data = sram_rdata, rd_field extracted using the latched sel. rd_valid is 0 in all other cycles. ch_part is ignored on reads; rd_field is always produced.

## Timing
- Grant latency 0 cycles from request when the arbiter is idle and the client wins.
- Read latency: data and rd_valid appear 1 cycle after grant. Back-to-back reads sustain 1 per cycle, from any mix of clients.
- Full write: 1 cycle. Field write: 2 cycles (G: read, G+1: merged write). The next grant is possible at G+2.
- Read granted at G+1 directly after a write at G to the same address returns the new word at G+2.
- Simultaneous requests: exactly one grant per cycle, round-robin. A client that keeps ch_req high is granted within N_CH grant slots.
- During RMW_MERGE, all ch_gnt are 0. Requests stay pending and are not dropped.
- Reset (asynchronous): state=IDLE, ptr=0, rd_valid=0, latched registers=0. While rst=1, all outputs are 0, including combinational ones.
- Reset asserted in RMW_MERGE aborts the merge; no write is issued.
- A read in flight when reset is asserted produces no rd_valid.

## Structure
- Package spk_mem_pkg:
  - state encoding (IDLE, RMW_MERGE)
  - clog2-based SEL_W helper
  - field-insert and field-extract functions shared with other spike-memory blocks
- Sub-module spk_rr_arbiter: takes N_CH request bits and the pointer, returns the one-hot grant and the next pointer. Purely combinational with no state; `ptr` lives in the parent.
- Datapath muxes (address, sel, wdata by grant) are implemented in the parent.

## Test plan
- Reset then single read: memory[5]=16'hA5C3; client 1 reads addr 5 with sel=3 → gnt[1] in G; rd_valid=4'b0010, rd_data=16'hA5C3, rd_field=2'b11 in G+1.
- Contention: all 4 clients request continuously from reset → grant order 0,1,2,3,0,… with one grant per cycle and no starvation.
- Field write: memory[9]=16'h0000; client 2 writes field sel=7 with data 2'b10 → sram_we=0 at G, sram_we=1 with sram_wdata=16'h8000 at G+1, no grant at G+1; a later read of addr 9 returns 16'h8000.
- Field write then full write by another client: the second client's gnt is delayed to G+2, and its write lands after the merge (final word = second client's data).
- Write-then-read: client 0 writes 16'h1234 to addr 3 at G; client 1 reads addr 3 at G+1 → rd_data=16'h1234 at G+2.
- Reset during RMW_MERGE: assert rst in G+1 of a field write → sram_we=0 immediately, memory unchanged, all outputs 0, ptr=0 after release.
